logarithmic_afpm: RTL and testbench
===================================

# logarithmic_afpm

Approximate FP16 multiplier based on Mitchell's logarithmic multiplication. It is the top-level user block of a TinyTapeout tile. Two half-precision operands arrive byte-serially on the dedicated and bidirectional input pins. The approximate product is returned byte-serially on the dedicated outputs under a fixed 8-cycle frame.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  when high the frame advances; when low all state holds.
- ui_in  in  8  operand A byte (low byte first, then high byte).
- uio_in  in  8  operand B byte (same slots as A).
- uo_out  out  8  result byte.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs).

## Operation
- Operand format: IEEE binary16, 1 sign / 5 exponent / 10 fraction bits, bias 15.
- Frame counter `cyc`, 3 bits, counts 0..7 and wraps. One frame is four phases of 2 cycles each:
  - P0 (cyc 0-1): low bytes. At the edge ending cyc 1: A_lo <= ui_in, B_lo <= uio_in.
  - P1 (cyc 2-3): high bytes. At the edge ending cyc 3: R <= mul({ui_in,A_lo}, {uio_in,B_lo}).
  - P2 (cyc 4-5): uo_out = R[15:8].
  - P3 (cyc 6-7): uo_out = R[7:0].
  - The following frame's P0 and P1 keep showing R[7:0].
- mul(), evaluated in this priority order:
  - sign = sa ^ sb.
  - NaN: either input NaN, or inf times zero -> 0x7E00.
  - Infinity: either input inf -> {sign, 0x7C00[14:0]}.
  - Zero: either exponent field 0 (subnormals flush to zero) -> {sign, 15'h0}.
  - Otherwise S = {ea,fa} + {eb,fb} - 15'h3C00. This is the Mitchell bit-pattern add: a fraction carry increments the exponent, and the fraction is the 10-bit wrapped sum.
  - Compute S in 17 signed bits. If the exponent part of S is <= 0, return signed zero. If it is >= 31, return signed infinity. Otherwise return {sign, S[14:0]}.
- uo_out is a combinational mux of R selected by cyc; no extra register.

## Timing
- Reset values: cyc = 0, A_lo = 0, B_lo = 0, R = 0, uo_out = 0x00.
- The first edge after rst falls is the edge ending cyc 0.
- Latency: the result high byte appears in the cycle immediately after the high bytes are sampled (cyc 4).
- Input bytes must be stable during the second cycle of their phase. The first cycle of each phase is don't-care.
- ena low: cyc, A_lo, B_lo and R all freeze, and uo_out holds its value. The frame resumes where it stopped.
- rst asserted mid-frame: at the next edge everything returns to reset values and any partial operand is discarded.
- rst has priority over ena.

## Configuration
- AFPM_SPECIALS_EN defined: NaN and infinity handling exactly as in Operation; overflow returns signed infinity.
- AFPM_SPECIALS_EN undefined:
  - Exponent 31 is treated as an ordinary finite exponent; no NaN is ever produced.
  - Overflow saturates to {sign, 15'h7BFF}.
  - Zero/subnormal flush and underflow-to-zero remain.

## Structure
- Package afpm_pkg holds:
  - field widths (EXP_W = 5, FRAC_W = 10) and BIAS = 15;
  - constants QNAN = 16'h7E00, INF_MAG = 15'h7C00, MAX_MAG = 15'h7BFF;
  - phase localparams P0..P3.
- One combinational sub-module, afpm_mitchell_core: two 16-bit inputs, one 16-bit output, and all special-case logic.
- The top level contains only the frame counter, byte registers and output mux.

## Test plan
- Subnormals: A = 0x0001, B = 0x0001 -> R = 0x0000; uo_out = 0x00 in cyc 4-7.
- Fraction carry: A = 0x3E00 (1.5), B = 0x4200 (3.0) -> R = 0x4400 (4.0, approximate); uo_out = 0x44 in cyc 4-5, then 0x00 in cyc 6-7.
- No carry, sign: A = 0xBC00 (-1), B = 0x4500 (5.0) -> R = 0xC500; uo_out = 0xC5 then 0x00.
- Overflow: A = 0x7800, B = 0x7800 -> with AFPM_SPECIALS_EN, 0x7C00; without it, 0x7BFF.
- Specials (macro defined): 0x7C00 x 0x0000 -> 0x7E00; 0x7C00 x 0xC000 -> 0xFC00.
- Control:
  - drop ena for 5 cycles in P1 -> result unchanged and delayed exactly 5 cycles;
  - assert rst in cyc 2 -> uo_out = 0x00 and the frame restarts at cyc 0.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared constants for the approximate FP16 Mitchell multiplier.
// Holds binary16 field widths, the exponent bias, special-value encodings
// and the byte-serial frame phase codes.
package afpm_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned BIAS   = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CYC_W  = 3;

    localparam logic [DATA_W-1:0] QNAN    = 16'h7E00;
    localparam logic [14:0]       INF_MAG = 15'h7C00;
    localparam logic [14:0]       MAX_MAG = 15'h7BFF;

    // Frame phase = cyc[2:1]
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

endpackage

// File: rtl/logarithmic_afpm_if.sv
// Pin bundle of the multiplier tile.
//   ena     : frame advance enable
//   ui_in   : operand A byte
//   uio_in  : operand B byte
//   uo_out  : result byte
//   uio_out : bidirectional output data (constant 0)
//   uio_oe  : bidirectional output enables (constant 0)
// master = pin driver (harness), slave = multiplier.
interface logarithmic_afpm_if;
    import afpm_pkg::*;

    logic              ena;
    logic [BYTE_W-1:0] ui_in;
    logic [BYTE_W-1:0] uio_in;
    logic [BYTE_W-1:0] uo_out;
    logic [BYTE_W-1:0] uio_out;
    logic [BYTE_W-1:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/afpm_mitchell_core.sv
// Combinational Mitchell-approximate binary16 multiply.
//   a_i, b_i : binary16 operands
//   p_o      : approximate binary16 product
// Build option: AFPM_SPECIALS_EN enables NaN/infinity handling and
// overflow-to-infinity; without it exponent 31 is finite and overflow
// saturates to the largest finite magnitude.
module afpm_mitchell_core
    import afpm_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] p_o
);

    localparam logic [16:0] BIAS_PAT = 17'(BIAS) << FRAC_W;

    logic             sgn;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic             a_zero;
    logic             b_zero;
    logic [16:0]      s;
    logic             uflow;
    logic             oflow;

    assign sgn    = a_i[15] ^ b_i[15];
    assign ea     = a_i[14:10];
    assign eb     = b_i[14:10];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    // Adding the exponent|fraction bit patterns adds the log2 approximations;
    // a fraction carry naturally ripples into the exponent.
    assign s     = {2'b00, a_i[14:0]} + {2'b00, b_i[14:0]} - BIAS_PAT;
    assign uflow = s[16] | (s[15:10] == 6'd0);
    assign oflow = ~s[16] & (s[15:10] >= 6'd31);

`ifdef AFPM_SPECIALS_EN
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;

    assign a_nan = (ea == '1) && (a_i[9:0] != '0);
    assign b_nan = (eb == '1) && (b_i[9:0] != '0);
    assign a_inf = (ea == '1) && (a_i[9:0] == '0);
    assign b_inf = (eb == '1) && (b_i[9:0] == '0);

    // Priority: NaN, infinity, zero operand, then range checks on the sum
    always_comb begin
        p_o = {sgn, s[14:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o = QNAN;
        end else if (a_inf || b_inf) begin
            p_o = {sgn, INF_MAG};
        end else if (a_zero || b_zero || uflow) begin
            p_o = {sgn, 15'h0000};
        end else if (oflow) begin
            p_o = {sgn, INF_MAG};
        end
    end
`else
    // Zero operands and underflow flush; overflow saturates
    always_comb begin
        p_o = {sgn, s[14:0]};
        if (a_zero || b_zero || uflow) begin
            p_o = {sgn, 15'h0000};
        end else if (oflow) begin
            p_o = {sgn, MAX_MAG};
        end
    end
`endif

endmodule

// File: rtl/logarithmic_afpm.sv
// Byte-serial approximate FP16 multiplier tile (8-cycle frame).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of logarithmic_afpm_if
//              (ena, ui_in, uio_in in; uo_out, uio_out, uio_oe out)
// Frame: cyc 0-1 low bytes, 2-3 high bytes, 4-5 result high byte,
// 6-7 and the next frame's 0-3 result low byte.
// Build option: AFPM_SPECIALS_EN (see afpm_mitchell_core).
module logarithmic_afpm
    import afpm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    logarithmic_afpm_if.slave  bus
);

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BYTE_W-1:0] a_lo_q, a_lo_d;
    logic [BYTE_W-1:0] b_lo_q, b_lo_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] prod;

    afpm_mitchell_core u_core (
        .a_i ({bus.ui_in,  a_lo_q}),
        .b_i ({bus.uio_in, b_lo_q}),
        .p_o (prod)
    );

    // Next state: capture low bytes at end of cyc 1, product at end of cyc 3
    always_comb begin
        cyc_d  = cyc_q;
        a_lo_d = a_lo_q;
        b_lo_d = b_lo_q;
        r_d    = r_q;
        if (bus.ena) begin
            cyc_d = cyc_q + 3'd1;
            if (cyc_q == 3'd1) begin
                a_lo_d = bus.ui_in;
                b_lo_d = bus.uio_in;
            end
            if (cyc_q == 3'd3) begin
                r_d = prod;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            a_lo_q <= '0;
            b_lo_q <= '0;
            r_q    <= '0;
        end else begin
            cyc_q  <= cyc_d;
            a_lo_q <= a_lo_d;
            b_lo_q <= b_lo_d;
            r_q    <= r_d;
        end
    end

    // High byte only in P2; every other phase shows the low byte
    assign bus.uo_out  = (cyc_q[2:1] == P2) ? r_q[15:8] : r_q[7:0];
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: byte-serial frames with
// randomized operands and ena stalls, compared every cycle against an
// arithmetic model of the Mitchell product.
module tb_logarithmic_afpm;

    logic clk;
    logic rst;
    logarithmic_afpm_if bus ();

    logarithmic_afpm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic        chk_en = 1'b0;
    logic [7:0]  exp_uo = 8'h00;
    logic [15:0] prev_r = 16'h0000;
    string       tag    = "reset";

    // Reference: plain integer arithmetic on the binary16 fields
    function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        int   ea, eb, fa, fb, s;
        logic sgn;
        sgn = a[15] ^ b[15];
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        fa  = int'(a[9:0]);
        fb  = int'(b[9:0]);
`ifdef AFPM_SPECIALS_EN
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0) ||
            (ea == 31 && eb == 0) || (eb == 31 && ea == 0))
            return 16'h7E00;
        if (ea == 31 || eb == 31)
            return {sgn, 15'h7C00};
`endif
        if (ea == 0 || eb == 0)
            return {sgn, 15'h0000};
        s = (ea * 1024 + fa) + (eb * 1024 + fb) - 15 * 1024;
        if (s < 1024)
            return {sgn, 15'h0000};
        if (s >= 31 * 1024) begin
`ifdef AFPM_SPECIALS_EN
            return {sgn, 15'h7C00};
`else
            return {sgn, 15'h7BFF};
`endif
        end
        return {sgn, 15'(s)};
    endfunction

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Per-cycle compare of the pins
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.uo_out !== exp_uo) begin
                errors++;
                $display("FAIL uo_out[%s] t=%0t: got %h expected %h", tag, $time, bus.uo_out, exp_uo);
            end
            checks++;
            if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
                errors++;
                $display("FAIL uio_pins[%s]: got out=%h oe=%h expected 00/00", tag, bus.uio_out, bus.uio_oe);
            end
        end
    end

    function automatic logic [7:0] exp_at(input int k, input logic [15:0] r, input logic [15:0] pr);
        if (k < 4) return pr[7:0];
        if (k < 6) return r[15:8];
        return r[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame starting at cyc 0; optional ena stall before slot stall_at
    task automatic frame(input logic [15:0] a, input logic [15:0] b,
                         input int stall_at, input int stall_len, input string name);
        logic [15:0] r;
        r   = model_mul(a, b);
        tag = name;
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                for (int j = 0; j < stall_len; j++) begin
                    bus.ena    = 1'b0;
                    bus.ui_in  = 8'($urandom);
                    bus.uio_in = 8'($urandom);
                    exp_uo     = exp_at(k, r, prev_r);
                    step();
                end
            end
            bus.ena = 1'b1;
            case (k)
                1: begin bus.ui_in = a[7:0];  bus.uio_in = b[7:0];  end
                3: begin bus.ui_in = a[15:8]; bus.uio_in = b[15:8]; end
                default: begin bus.ui_in = 8'($urandom); bus.uio_in = 8'($urandom); end
            endcase
            exp_uo = exp_at(k, r, prev_r);
            step();
        end
        prev_r = r;
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 5))
            0: ;
            1: v[14:10] = 5'd0;
            2: v[14:10] = 5'd31;
            3: v[14:10] = 5'($urandom_range(13, 17));
            4: v[14:10] = 5'($urandom_range(25, 30));
            default: v[14:10] = 5'($urandom_range(1, 6));
        endcase
        if ($urandom_range(0, 3) == 0) v[9:0] = 10'd0;
        return v;
    endfunction

    initial begin
        // Pin the model with hand-computed values
        chk16("model_subnormal", model_mul(16'h0001, 16'h0001), 16'h0000);
        chk16("model_carry",     model_mul(16'h3E00, 16'h4200), 16'h4400);
        chk16("model_sign",      model_mul(16'hBC00, 16'h4500), 16'hC500);
`ifdef AFPM_SPECIALS_EN
        chk16("model_overflow",  model_mul(16'h7800, 16'h7800), 16'h7C00);
        chk16("model_inf_zero",  model_mul(16'h7C00, 16'h0000), 16'h7E00);
        chk16("model_inf_neg",   model_mul(16'h7C00, 16'hC000), 16'hFC00);
`else
        chk16("model_overflow",  model_mul(16'h7800, 16'h7800), 16'h7BFF);
`endif

        // Reset
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        step();
        chk_en = 1'b1;
        exp_uo = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Directed frames
        frame(16'h0001, 16'h0001, -1, 0, "subnormal");
        frame(16'h3E00, 16'h4200, -1, 0, "carry");
        frame(16'hBC00, 16'h4500, -1, 0, "sign");
        frame(16'h7800, 16'h7800, -1, 0, "overflow");
`ifdef AFPM_SPECIALS_EN
        frame(16'h7C00, 16'h0000, -1, 0, "inf_x_zero");
        frame(16'h7C00, 16'hC000, -1, 0, "inf_x_neg");
`endif
        // ena low 5 cycles in P1: result delayed by exactly 5 cycles
        frame(16'h3E00, 16'h4200, 3, 5, "ena_stall");

        // Reset mid-frame in cyc 2 (with ena low: reset wins)
        tag        = "rst_mid";
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h11; bus.uio_in = 8'h22; exp_uo = prev_r[7:0]; step();
        bus.ui_in  = 8'h33; bus.uio_in = 8'h44; exp_uo = prev_r[7:0]; step();
        rst        = 1'b1;
        bus.ena    = 1'b0;
        exp_uo     = prev_r[7:0];
        step();
        rst        = 1'b0;
        prev_r     = 16'h0000;
        frame(16'hBC00, 16'h4500, -1, 0, "after_rst");

        // Randomized frames with occasional stalls
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                frame(rand_op(), rand_op(), int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), "random_stall");
            else
                frame(rand_op(), rand_op(), -1, 0, "random");
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
